// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer.
package pipe_ctrl_pkg;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } ctrl_state_e;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_flush;
        logic ex_mem_en;
        logic mem_wb_en;
        logic mem_wb_flush;
    } stage_ctrl_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Every stage advances, nothing is squashed.
    localparam stage_ctrl_t CTRL_RUN = '{
        pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0, id_ex_en: 1'b1,
        id_ex_flush: 1'b0, ex_mem_en: 1'b1, mem_wb_en: 1'b1, mem_wb_flush: 1'b0
    };

    // Upstream stages hold; MEM/WB takes a bubble so the stalled access
    // is not written back twice.
    localparam stage_ctrl_t CTRL_FREEZE = '{
        pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0, id_ex_en: 1'b0,
        id_ex_flush: 1'b0, ex_mem_en: 1'b0, mem_wb_en: 1'b1, mem_wb_flush: 1'b1
    };

    // Values forced while rst_n is low.
    localparam stage_ctrl_t CTRL_RESET = '{
        pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b1, id_ex_en: 1'b0,
        id_ex_flush: 1'b1, ex_mem_en: 1'b0, mem_wb_en: 1'b0, mem_wb_flush: 1'b1
    };

endpackage

// File: rtl/pipeline_ctrl_load_use_detect.sv
// Load-use hazard compare: a load in EX whose destination feeds the
// instruction currently in ID.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    input  logic       id_valid,
    input  logic [4:0] id_rs1_id,
    input  logic [4:0] id_rs2_id,
    input  logic       id_uses_rs2,
    output logic       hazard
);

    logic rs1_match;
    logic rs2_match;

    // x0 is never a real dependency, so a load targeting it never stalls.
    always_comb begin
        rs1_match = (ex_rd == id_rs1_id);
        rs2_match = id_uses_rs2 && (ex_rd == id_rs2_id);
        hazard    = ex_valid && ex_mem_read && (ex_rd != REG_ZERO) &&
                    id_valid && (rs1_match || rs2_match);
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central sequencer for the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
//
// Data-memory handshake: dmem_req is high whenever EX/MEM holds a load or
// store and stays high until the cycle dmem_ready is sampled high; that
// cycle completes the access. dmem_ready while dmem_req is low is ignored.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [4:0]        id_rs1_id,
    input  logic [4:0]        id_rs2_id,
    input  logic              id_uses_rs2,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [4:0]        ex_rd,
    input  logic              ex_branch_taken,
    input  logic [31:0]       ex_branch_target,
    input  logic              mem_valid,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              dmem_ready,
    output logic              dmem_req,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              if_id_flush,
    output logic              id_ex_en,
    output logic              id_ex_flush,
    output logic              ex_mem_en,
    output logic              mem_wb_en,
    output logic              mem_wb_flush,
    output logic              redirect_valid,
    output logic [31:0]       redirect_pc,
    output logic              dmem_err,
`ifdef PIPE_CTRL_PERF_EN
    output logic [CNT_W-1:0]  perf_cycles,
    output logic [CNT_W-1:0]  perf_stalls,
    output logic [CNT_W-1:0]  perf_flushes,
`endif
    output ctrl_state_e       state
);

    localparam int              TO_W    = $clog2(MEM_TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    if (MEM_TIMEOUT < 2 || CNT_W < 1) begin : g_param_check
        $error("pipeline_ctrl: MEM_TIMEOUT must be >= 2 and CNT_W >= 1");
    end

    ctrl_state_e     state_next;
    logic [TO_W-1:0] to_cnt;
    logic [TO_W-1:0] to_cnt_next;
    logic            err_set;
    logic            dmem_err_q;
    logic            mem_acc;
    logic            branch_taken;
    logic            load_use;
    logic            freeze;
    logic            redirect;
    stage_ctrl_t     normal_ctrl;
    stage_ctrl_t     ctrl;
    stage_ctrl_t     ctrl_out;

    assign mem_acc      = mem_valid && (mem_read || mem_write);
    assign branch_taken = ex_valid && ex_branch_taken;

    load_use_detect u_load_use_detect (
        .ex_valid    (ex_valid),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .id_valid    (id_valid),
        .id_rs1_id   (id_rs1_id),
        .id_rs2_id   (id_rs2_id),
        .id_uses_rs2 (id_uses_rs2),
        .hazard      (load_use)
    );

    // Unfrozen stage controls: a taken branch outranks load-use because the
    // dependent instruction in ID is being discarded anyway.
    always_comb begin
        normal_ctrl = CTRL_RUN;
        if (branch_taken) begin
            normal_ctrl.if_id_flush = 1'b1;
            normal_ctrl.id_ex_flush = 1'b1;
        end else if (load_use) begin
            normal_ctrl.pc_en       = 1'b0;
            normal_ctrl.if_id_en    = 1'b0;
            normal_ctrl.id_ex_flush = 1'b1;
        end
    end

    // Next-state, watchdog and freeze selection.
    always_comb begin
        state_next  = state;
        to_cnt_next = to_cnt;
        err_set     = 1'b0;
        freeze      = 1'b0;
        ctrl        = normal_ctrl;
        unique case (state)
            RUN: begin
                if (mem_acc && !dmem_ready) begin
                    state_next  = MEM_WAIT;
                    to_cnt_next = '0;
                    freeze      = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_next  = RUN;
                    to_cnt_next = '0;
                end else if (to_cnt == TO_LAST) begin
                    // Abort: drop the access but let everything else move.
                    state_next        = RUN;
                    to_cnt_next       = '0;
                    err_set           = 1'b1;
                    ctrl.mem_wb_flush = 1'b1;
                end else begin
                    to_cnt_next = to_cnt + 1'b1;
                    freeze      = 1'b1;
                end
            end
            default: begin
                state_next  = RUN;
                to_cnt_next = '0;
            end
        endcase
        if (freeze) begin
            ctrl = CTRL_FREEZE;
        end
        // A branch held in EX during a freeze acts only once released.
        redirect = branch_taken && !freeze;
    end

    // State, watchdog counter and sticky error register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            to_cnt     <= '0;
            dmem_err_q <= 1'b0;
        end else begin
            state      <= state_next;
            to_cnt     <= to_cnt_next;
            dmem_err_q <= dmem_err_q || err_set;
        end
    end

    // Output drive, overridden combinationally while reset is asserted.
    always_comb begin
        if (!rst_n) begin
            ctrl_out       = CTRL_RESET;
            dmem_req       = 1'b0;
            redirect_valid = 1'b0;
            redirect_pc    = 32'd0;
        end else begin
            ctrl_out       = ctrl;
            dmem_req       = mem_acc;
            redirect_valid = redirect;
            redirect_pc    = redirect ? ex_branch_target : 32'd0;
        end
    end

    assign pc_en        = ctrl_out.pc_en;
    assign if_id_en     = ctrl_out.if_id_en;
    assign if_id_flush  = ctrl_out.if_id_flush;
    assign id_ex_en     = ctrl_out.id_ex_en;
    assign id_ex_flush  = ctrl_out.id_ex_flush;
    assign ex_mem_en    = ctrl_out.ex_mem_en;
    assign mem_wb_en    = ctrl_out.mem_wb_en;
    assign mem_wb_flush = ctrl_out.mem_wb_flush;
    assign dmem_err     = dmem_err_q;

`ifdef PIPE_CTRL_PERF_EN
    logic stall_cycle;
    assign stall_cycle = freeze || (load_use && !branch_taken);

    // Saturating performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles  <= '0;
            perf_stalls  <= '0;
            perf_flushes <= '0;
        end else begin
            if (perf_cycles != '1) begin
                perf_cycles <= perf_cycles + 1'b1;
            end
            if (stall_cycle && perf_stalls != '1) begin
                perf_stalls <= perf_stalls + 1'b1;
            end
            if (redirect && perf_flushes != '1) begin
                perf_flushes <= perf_flushes + 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central sequencer for the 5-stage pipeline registers: IF/ID, ID/EX, EX/MEM and MEM/WB.
- Generates per-stage enable and flush/bubble controls.
- Inserts load-use bubbles and redirects fetch on a taken branch.
- Freezes the pipeline while a data-memory access is outstanding.
- A watchdog aborts hung memory accesses.

Parameters:
MEM_TIMEOUT, 64, max cycles in MEM_WAIT before abort (≥2)
CNT_W, 32, width of perf counters (optional feature)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  IF/ID holds a valid instruction
id_rs1_id  in  5  IF/ID source register 1
id_rs2_id  in  5  IF/ID source register 2
id_uses_rs2  in  1  instruction in ID reads rs2
ex_valid  in  1  ID/EX valid
ex_mem_read  in  1  ID/EX is a load
ex_rd  in  5  ID/EX destination
ex_branch_taken  in  1  branch resolved taken in EX
ex_branch_target  in  32  resolved target PC
mem_valid  in  1  EX/MEM valid
mem_read  in  1  EX/MEM load
mem_write  in  1  EX/MEM store
dmem_ready  in  1  data memory completes access this cycle
dmem_req  out  1  data memory request
pc_en  out  1  PC update enable
if_id_en  out  1  IF/ID load enable
if_id_flush  out  1  IF/ID valid cleared on next edge
id_ex_en  out  1  ID/EX load enable
id_ex_flush  out  1  ID/EX loads bubble (valid=0)
ex_mem_en  out  1  EX/MEM load enable
mem_wb_en  out  1  MEM/WB load enable
mem_wb_flush  out  1  MEM/WB loads bubble
redirect_valid  out  1  fetch must load redirect_pc
redirect_pc  out  32  new fetch PC
dmem_err  out  1  sticky: memory timeout occurred

Behaviour:
- Clock/reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- While rst_n=0, outputs are forced combinationally:
  - all *_en=0
  - if_id_flush=id_ex_flush=mem_wb_flush=1
  - dmem_req=0, redirect_valid=0, redirect_pc=0
  - dmem_err=0, state=RUN, timeout counter=0
- FSM states: RUN, MEM_WAIT.
- mem_acc = mem_valid & (mem_read|mem_write).
- dmem_req = mem_acc in either state. Requester holds the request until dmem_ready; dmem_ready without dmem_req is ignored.
- RUN, mem_acc & !dmem_ready:
  - Go to MEM_WAIT, timeout counter cleared.
  - This cycle: freeze (see below).
- Freeze definition:
  - pc_en=if_id_en=id_ex_en=ex_mem_en=0.
  - mem_wb_en=1 with mem_wb_flush=1, so no duplicate writeback.
  - Branch redirect and load-use logic are suppressed; the branch stays in EX and acts on release.
- MEM_WAIT:
  - Freeze continues; counter increments each cycle.
  - dmem_ready=1: go to RUN; this cycle behaves as a normal RUN cycle, so the access completes into MEM/WB.
  - Counter reaches MEM_TIMEOUT-1 without ready: set dmem_err, go to RUN. That cycle mem_wb_flush=1 (access dropped), ex_mem_en=1, other stages advance normally.
- Normal RUN cycle: all enables=1, flushes=0 unless overridden, priority highest first:
  1. Taken branch (ex_valid & ex_branch_taken):
     - redirect_valid=1, redirect_pc=ex_branch_target.
     - if_id_flush=1, id_ex_flush=1, pc_en=1.
     - Any load-use hazard is ignored, since the ID instruction is discarded.
  2. Load-use:
     - Condition: ex_valid & ex_mem_read & ex_rd≠0 & id_valid & (ex_rd==id_rs1_id | (id_uses_rs2 & ex_rd==id_rs2_id)).
     - Response: pc_en=0, if_id_en=0, id_ex_flush=1, for exactly one cycle (the load leaves EX next edge).
- redirect_pc is 0 when redirect_valid=0.
- dmem_err is cleared only by reset.
- Reset asserted mid-MEM_WAIT: immediate return to RUN, counter cleared.

Optional Feature:
PIPE_CTRL_PERF_EN
- Defined: adds outputs perf_cycles, perf_stalls, perf_flushes, each CNT_W wide, reset 0, saturating.
  - perf_cycles: counts every cycle out of reset.
  - perf_stalls: counts freeze or load-use cycles.
  - perf_flushes: counts redirect cycles.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- pipe_ctrl_pkg:
  - enum ctrl_state_e {RUN, MEM_WAIT}
  - packed struct stage_ctrl_t {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en, mem_wb_flush}
  - constant REG_ZERO=5'd0
- Sub-module load_use_detect (combinational hazard compare), instantiated once.
- FSM, watchdog and priority mux stay in pipeline_ctrl.

Test Plan:
1. Reset release with idle inputs -> next cycle all enables=1, flushes=0, redirect_valid=0, dmem_req=0.
2. Load-use, x5:
   - Stimulus: ex_mem_read=1, ex_rd=5, id_rs2_id=5, id_uses_rs2=1.
   - Response: one cycle pc_en=0, if_id_en=0, id_ex_flush=1.
   - Repeat with ex_rd=0 -> no stall.
3. Store with dmem_ready low 3 cycles:
   - dmem_req high 4 cycles; freeze for 3 cycles with mem_wb_flush=1.
   - 4th cycle: all enables=1, mem_wb_flush=0.
4. Taken branch, target 0x0000_0100, same cycle as load-use hazard -> redirect_valid=1, redirect_pc=0x100, if_id_flush=id_ex_flush=1, pc_en=1.
5. Taken branch during MEM_WAIT -> no redirect while frozen; redirect asserted on the dmem_ready cycle.
6. MEM_TIMEOUT=4, dmem_ready held 0:
   - After 4 freeze cycles, dmem_err=1, state RUN, access dropped (mem_wb_flush=1).
   - Assert rst_n=0 mid-wait in a second run -> outputs go to reset values immediately.
